// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the Goldcrest RV32I control sequencer:
// opcodes, FSM states, immediate formats, writeback and FU select codes.
package rv_ctrl_pkg;

  // Major opcodes handled by the sequencer
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  // Immediate layouts; SHAMT is the 5-bit shift amount of SLLI/SRLI/SRAI
  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_fmt_t;

  // Writeback source codes
  localparam logic [1:0] WB_FU   = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  // FU operation selects (funct3 encoding) and modifier
  localparam logic [2:0] FU_ADD  = 3'b000;
  localparam logic [2:0] FU_SLL  = 3'b001;
  localparam logic [2:0] FU_SLT  = 3'b010;
  localparam logic [2:0] FU_SLTU = 3'b011;
  localparam logic [2:0] FU_XOR  = 3'b100;
  localparam logic [2:0] FU_SR   = 3'b101;
  localparam logic [2:0] FU_OR   = 3'b110;
  localparam logic [2:0] FU_AND  = 3'b111;
  localparam logic       FU_MOD_NONE = 1'b0;
  localparam logic       FU_MOD_SUB  = 1'b1;

  // Branch condition funct3 codes
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // True for the funct3 values that route ALU-class ops to the shifter
  function automatic logic is_shift_funct3(input logic [2:0] funct3);
    return (funct3 == FU_SLL) || (funct3 == FU_SR);
  endfunction

  // Branch funct3 010/011 are reserved
  function automatic logic branch_funct3_valid(input logic [2:0] funct3);
    return (funct3 != 3'b010) && (funct3 != 3'b011);
  endfunction

  // Resolve a branch from the flags of rs1 - rs2; C=1 means no borrow
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic v, input logic c,
                                        input logic n, input logic z);
    logic t;
    case (funct3)
      BR_BEQ:  t = z;
      BR_BNE:  t = ~z;
      BR_BLT:  t = n ^ v;
      BR_BGE:  t = ~(n ^ v);
      BR_BLTU: t = ~c;
      BR_BGEU: t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate extraction: picks the immediate layout named by
// fmt out of the instruction word and sign-extends it to 32 bits.
module rv_imm_gen
  import rv_ctrl_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  // Select and sign-extend the immediate for the current format
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm = {instr[31:12], 12'h000};
      IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12],
                        instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: imm = {27'd0, instr[24:20]};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle control sequencer for the Goldcrest RV32I core. Fetches an
// instruction, decodes it into FU / operand-mux controls, resolves branches
// from the FU flags and sequences data access, writeback and PC update.
module rv_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR = 32'h0000_0013
)(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [2:0]  fu_select,
  output logic        fu_select_2,
  output logic        fu_sel_shift,
  input  logic        fu_v,
  input  logic        fu_c,
  input  logic        fu_n,
  input  logic        fu_z,
  output logic        src_b_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic        pc_en,
  output logic        pc_branch,
  output logic        illegal
);

  state_t      state_reg, state_next;
  logic [31:0] ir_reg;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  imm_fmt_t    imm_fmt;
  logic        dec_legal;
  logic        dec_branch;
  logic        dec_mem;
  logic        dec_jal;
  logic        br_taken;

  assign opcode = ir_reg[6:0];
  assign funct3 = ir_reg[14:12];
  assign rs1    = ir_reg[19:15];
  assign rs2    = ir_reg[24:20];
  assign rd     = ir_reg[11:7];

  // State register; reset always returns to a fresh fetch and drops any
  // data request in flight, so a pending ack is simply never consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Instruction register loads only on an ack to our own fetch request
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_reg <= RESET_IR;
    end else if (state_reg == ST_FETCH && imem_ack) begin
      ir_reg <= imem_rdata;
    end
  end

  // Instruction decode: pure function of IR, valid from DECODE onwards
  always_comb begin
    fu_select    = FU_ADD;
    fu_select_2  = FU_MOD_NONE;
    fu_sel_shift = 1'b0;
    src_b_imm    = 1'b1;
    wb_sel       = WB_FU;
    dmem_we      = 1'b0;
    imm_fmt      = IMM_NONE;
    dec_legal    = 1'b1;
    dec_branch   = 1'b0;
    dec_mem      = 1'b0;
    dec_jal      = 1'b0;
    case (opcode)
      OPC_OP: begin
        fu_select    = funct3;
        fu_select_2  = ir_reg[30];
        fu_sel_shift = is_shift_funct3(funct3);
        src_b_imm    = 1'b0;
      end
      OPC_OP_IMM: begin
        fu_select    = funct3;
        // Only SRAI carries a modifier; ADDI has no SUBI counterpart
        fu_select_2  = (funct3 == FU_SR) ? ir_reg[30] : FU_MOD_NONE;
        fu_sel_shift = is_shift_funct3(funct3);
        imm_fmt      = is_shift_funct3(funct3) ? IMM_SHAMT : IMM_I;
      end
      OPC_LOAD: begin
        wb_sel  = WB_LOAD;
        imm_fmt = IMM_I;
        dec_mem = 1'b1;
      end
      OPC_STORE: begin
        dmem_we = 1'b1;
        imm_fmt = IMM_S;
        dec_mem = 1'b1;
      end
      OPC_BRANCH: begin
        // Compare is rs1 - rs2 through the ALU
        fu_select   = FU_ADD;
        fu_select_2 = FU_MOD_SUB;
        src_b_imm   = 1'b0;
        imm_fmt     = IMM_B;
        dec_branch  = 1'b1;
        dec_legal   = branch_funct3_valid(funct3);
      end
      OPC_LUI: begin
        wb_sel  = WB_IMM;
        imm_fmt = IMM_U;
      end
      OPC_JAL: begin
        wb_sel  = WB_PC4;
        imm_fmt = IMM_J;
        dec_jal = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  rv_imm_gen u_imm_gen (
    .instr (ir_reg[31:7]),
    .fmt   (imm_fmt),
    .imm   (imm)
  );

  assign br_taken = branch_taken(funct3, fu_v, fu_c, fu_n, fu_z);
  assign illegal  = (state_reg == ST_TRAP);

  // Next-state and strobe generation
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    rf_we      = 1'b0;
    pc_en      = 1'b0;
    pc_branch  = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = dec_legal ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        if (dec_branch) begin
          // Branch retires here; flags are valid only in this cycle
          pc_en      = 1'b1;
          pc_branch  = br_taken;
          state_next = ST_FETCH;
        end else if (dec_mem) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (dmem_we) begin
            pc_en      = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we      = (rd != 5'd0);
        pc_en      = 1'b1;
        pc_branch  = dec_jal;
        state_next = ST_FETCH;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Directed testbench for rv_ctrl_fsm: hand-encoded instructions with
// hand-computed decode values and strobe timing.
module tb_rv_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [2:0]  fu_select;
  logic        fu_select_2;
  logic        fu_sel_shift;
  logic        fu_v, fu_c, fu_n, fu_z;
  logic        src_b_imm;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  wb_sel;
  logic        rf_we;
  logic        pc_en;
  logic        pc_branch;
  logic        illegal;

  int n_total;
  int n_bad;

  rv_ctrl_fsm #(.RESET_IR(32'h0000_0013)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .fu_select    (fu_select),
    .fu_select_2  (fu_select_2),
    .fu_sel_shift (fu_sel_shift),
    .fu_v         (fu_v),
    .fu_c         (fu_c),
    .fu_n         (fu_n),
    .fu_z         (fu_z),
    .src_b_imm    (src_b_imm),
    .imm          (imm),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .wb_sel       (wb_sel),
    .rf_we        (rf_we),
    .pc_en        (pc_en),
    .pc_branch    (pc_branch),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch cycle with same-cycle ack; returns in DECODE
  task automatic fetch(input logic [31:0] instr, input string tag);
    chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    $display("fetched %s instr=%h", tag, instr);
  endtask

  // Decode checks common to every instruction
  task automatic chk_dec(input string tag, input logic [2:0] sel, input logic sel2,
                         input logic shf, input logic bimm, input logic [31:0] im);
    chk({tag, " fu_select"},    {29'd0, fu_select},    {29'd0, sel});
    chk({tag, " fu_select_2"},  {31'd0, fu_select_2},  {31'd0, sel2});
    chk({tag, " fu_sel_shift"}, {31'd0, fu_sel_shift}, {31'd0, shf});
    chk({tag, " src_b_imm"},    {31'd0, src_b_imm},    {31'd0, bimm});
    chk({tag, " imm"},          imm,                   im);
  endtask

  // Strobe vector {imem_req, dmem_req, rf_we, pc_en, pc_branch}
  task automatic chk_strb(input string tag, input logic [4:0] exp);
    chk({tag, " strobes"}, {27'd0, imem_req, dmem_req, rf_we, pc_en, pc_branch},
        {27'd0, exp});
  endtask

  // ALU-class instruction through DECODE/EXECUTE/WB
  task automatic run_wb(input logic [31:0] instr, input string tag,
                        input logic [2:0] sel, input logic sel2, input logic shf,
                        input logic bimm, input logic [31:0] im,
                        input logic [4:0] exp_rd, input logic [1:0] exp_wb,
                        input logic exp_we, input logic exp_br);
    fetch(instr, tag);
    chk_dec(tag, sel, sel2, shf, bimm, im);
    chk_strb({tag, " c2"}, 5'b00000);
    step();
    chk_strb({tag, " c3"}, 5'b00000);
    step();
    chk_strb({tag, " c4"}, {2'b00, exp_we, 1'b1, exp_br});
    chk({tag, " rd"},     {27'd0, rd},     {27'd0, exp_rd});
    chk({tag, " wb_sel"}, {30'd0, wb_sel}, {30'd0, exp_wb});
    step();
    chk_strb({tag, " c5"}, 5'b10000);
  endtask

  // Branch: flags applied for EXECUTE, retires in cycle 3
  task automatic run_br(input logic [31:0] instr, input string tag,
                        input logic [3:0] vcnz, input logic [31:0] im,
                        input logic exp_taken);
    fetch(instr, tag);
    chk_dec(tag, 3'b000, 1'b1, 1'b0, 1'b0, im);
    {fu_v, fu_c, fu_n, fu_z} = vcnz;
    step();
    chk_strb({tag, " c3"}, {3'b000, 1'b1, exp_taken});
    step();
    {fu_v, fu_c, fu_n, fu_z} = 4'b0000;
    chk_strb({tag, " c4"}, 5'b10000);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    {fu_v, fu_c, fu_n, fu_z} = 4'b0000;

    // Reset state
    step();
    step();
    chk("rst illegal",      {31'd0, illegal},      32'd0);
    chk("rst fu_select",    {29'd0, fu_select},    32'd0);
    chk("rst fu_select_2",  {31'd0, fu_select_2},  32'd0);
    chk("rst fu_sel_shift", {31'd0, fu_sel_shift}, 32'd0);
    chk("rst imm",          imm,                   32'd0);
    chk("rst rd",           {27'd0, rd},           32'd0);
    chk("rst wb_sel",       {30'd0, wb_sel},       32'd0);
    rst = 1'b0;
    #1;
    chk_strb("rst", 5'b10000);

    // ADD x3,x1,x2
    run_wb(32'h002081B3, "ADD", 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 5'd3, 2'd0, 1'b1, 1'b0);
    // SRAI x5,x5,3
    run_wb(32'h4032D293, "SRAI", 3'b101, 1'b1, 1'b1, 1'b1, 32'd3, 5'd5, 2'd0, 1'b1, 1'b0);
    // ADDI x1,x0,-1
    run_wb(32'hFFF00093, "ADDI", 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd1, 2'd0, 1'b1, 1'b0);
    // ADD x0,x1,x2: write suppressed, PC still advances
    run_wb(32'h00208033, "ADDx0", 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    // SUB x4,x1,x2
    run_wb(32'h40208233, "SUB", 3'b000, 1'b1, 1'b0, 1'b0, 32'd0, 5'd4, 2'd0, 1'b1, 1'b0);
    // LUI x7,0x12345
    run_wb(32'h123453B7, "LUI", 3'b000, 1'b0, 1'b0, 1'b1, 32'h1234_5000, 5'd7, 2'd3, 1'b1, 1'b0);
    // JAL x1,+16
    run_wb(32'h010000EF, "JAL", 3'b000, 1'b0, 1'b0, 1'b1, 32'd16, 5'd1, 2'd2, 1'b1, 1'b1);

    // Branches, flags {V,C,N,Z}
    run_br(32'h0020C463, "BLT",  4'b0010, 32'd8, 1'b1);
    run_br(32'h0020F463, "BGEU", 4'b0000, 32'd8, 1'b0);
    run_br(32'h0020F463, "BGEUc", 4'b0100, 32'd8, 1'b1);
    run_br(32'h00209463, "BNE",  4'b0001, 32'd8, 1'b0);
    run_br(32'h00208463, "BEQ",  4'b0001, 32'd8, 1'b1);
    run_br(32'h0020D463, "BGE",  4'b1010, 32'd8, 1'b1);

    // LW x6,4(x1) with ack on the 4th MEM cycle
    fetch(32'h0040A303, "LW");
    chk_dec("LW", 3'b000, 1'b0, 1'b0, 1'b1, 32'd4);
    step();
    chk_strb("LW c3", 5'b00000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_strb($sformatf("LW mem%0d", k), 5'b01000);
      chk($sformatf("LW we%0d", k), {31'd0, dmem_we}, 32'd0);
      if (k == 3) dmem_ack = 1'b1;
    end
    step();
    dmem_ack = 1'b0;
    chk_strb("LW wb", 5'b00110);
    chk("LW wb_sel", {30'd0, wb_sel}, 32'd1);
    chk("LW rd",     {27'd0, rd},     32'd6);
    step();
    chk_strb("LW done", 5'b10000);

    // SW x2,8(x1) with stray acks in DECODE/EXECUTE that must be ignored
    fetch(32'h0020A423, "SW");
    chk_dec("SW", 3'b000, 1'b0, 1'b0, 1'b1, 32'd8);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_007F;
    dmem_ack   = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("SW stray imm",     imm,                   32'd8);
    chk("SW stray illegal", {31'd0, illegal},      32'd0);
    chk_strb("SW c3", 5'b00000);
    step();
    chk_strb("SW c4", 5'b01010);
    chk("SW we", {31'd0, dmem_we}, 32'd1);
    step();
    dmem_ack = 1'b0;
    chk_strb("SW done", 5'b10000);

    // Reset while a load waits for its data ack
    fetch(32'h0040A303, "LWrst");
    step();
    step();
    chk_strb("LWrst mem", 5'b01000);
    rst      = 1'b1;
    dmem_ack = 1'b1;
    step();
    rst      = 1'b0;
    dmem_ack = 1'b0;
    chk_strb("LWrst after", 5'b10000);

    // Unsupported opcode traps until reset
    fetch(32'h0000_007F, "ILL");
    step();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("ILL illegal%0d", k), {31'd0, illegal}, 32'd1);
      chk_strb($sformatf("ILL c%0d", k), 5'b00000);
      imem_ack = (k % 3 == 0);
      dmem_ack = (k % 4 == 1);
      step();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ILL cleared", {31'd0, illegal}, 32'd0);
    chk_strb("ILL refetch", 5'b10000);

    // Reserved branch funct3 010 traps too
    fetch(32'h0020A463, "BRRES");
    step();
    chk("BRRES illegal", {31'd0, illegal}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
